// File: rtl/uart_cmd_parser.sv
// Host command framer: sync, cmd, data_hi, data_lo[, checksum] -> {cmd, data} valid/ready port.
// Define UART_CMD_CHECKSUM_EN to append and verify an XOR checksum byte.
module uart_cmd_parser #(
    parameter logic [7:0]  SyncByte     = 8'hA5,
    parameter int unsigned TimeoutTicks = 640,
    parameter int unsigned TimerWidth   = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rx_done_tick_i,
    input  logic [7:0]  rx_data_i,
    input  logic        sample_tick_i,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic [7:0]  cmd_o,
    output logic [15:0] data_o,
    output logic        err_o,
    output logic [1:0]  err_code_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StDath,
        StDatl,
        StChk,
        StHold
    } state_e;

    localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TimeoutTicks - 1);
    localparam logic [1:0] ErrTimeout = 2'b01;
    localparam logic [1:0] ErrOverrun = 2'b11;
`ifdef UART_CMD_CHECKSUM_EN
    localparam logic [1:0] ErrChecksum = 2'b10;
`endif

    state_e                state_q, state_d;
    logic [TimerWidth-1:0] timer_q, timer_d;
    logic [7:0]            acc_q, acc_d;
    logic [7:0]            cmd_f_q, cmd_f_d;
    logic [7:0]            dhi_f_q, dhi_f_d;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]            dlo_f_q, dlo_f_d;
`endif
    logic [7:0]            cmd_q, cmd_d;
    logic [15:0]           data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic [1:0]            code_q, code_d;

    logic in_frame;
    logic timeout;
    logic is_sync;

    assign in_frame = (state_q == StCmd) || (state_q == StDath) ||
                      (state_q == StDatl) || (state_q == StChk);
    assign is_sync  = rx_done_tick_i && (rx_data_i == SyncByte);

    // Inter-byte timer: an arriving byte always clears it, even on the terminal tick.
    always_comb begin
        timer_d = '0;
        timeout = 1'b0;
        if (in_frame && !rx_done_tick_i) begin
            if (sample_tick_i) begin
                if (timer_q == TimerLast) begin
                    timeout = 1'b1;
                end else begin
                    timer_d = timer_q + TimerWidth'(1);
                end
            end else begin
                timer_d = timer_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cmd_f_d = cmd_f_q;
        dhi_f_d = dhi_f_q;
`ifdef UART_CMD_CHECKSUM_EN
        dlo_f_d = dlo_f_q;
`endif
        cmd_d   = cmd_q;
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        code_d  = code_q;

        unique case (state_q)
            StIdle: begin
                if (is_sync) begin
                    state_d = StCmd;
                    acc_d   = '0;
                end
            end
            StCmd: begin
                if (rx_done_tick_i) begin
                    cmd_f_d = rx_data_i;
                    acc_d   = acc_q ^ rx_data_i;
                    state_d = StDath;
                end
            end
            StDath: begin
                if (rx_done_tick_i) begin
                    dhi_f_d = rx_data_i;
                    acc_d   = acc_q ^ rx_data_i;
                    state_d = StDatl;
                end
            end
            StDatl: begin
                if (rx_done_tick_i) begin
                    acc_d = acc_q ^ rx_data_i;
`ifdef UART_CMD_CHECKSUM_EN
                    dlo_f_d = rx_data_i;
                    state_d = StChk;
`else
                    cmd_d   = cmd_f_q;
                    data_d  = {dhi_f_q, rx_data_i};
                    valid_d = 1'b1;
                    state_d = StHold;
`endif
                end
            end
            StChk: begin
`ifdef UART_CMD_CHECKSUM_EN
                if (rx_done_tick_i) begin
                    if (rx_data_i == acc_q) begin
                        cmd_d   = cmd_f_q;
                        data_d  = {dhi_f_q, dlo_f_q};
                        valid_d = 1'b1;
                        state_d = StHold;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ErrChecksum;
                        state_d = StIdle;
                    end
                end
`else
                state_d = StIdle;
`endif
            end
            StHold: begin
                // A byte arriving with the handshake is treated as the first byte seen in idle.
                if (cmd_ready_i) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                    if (is_sync) begin
                        state_d = StCmd;
                        acc_d   = '0;
                    end
                end else if (rx_done_tick_i) begin
                    err_d  = 1'b1;
                    code_d = ErrOverrun;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (timeout) begin
            err_d   = 1'b1;
            code_d  = ErrTimeout;
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            timer_q <= '0;
            acc_q   <= '0;
            cmd_f_q <= '0;
            dhi_f_q <= '0;
`ifdef UART_CMD_CHECKSUM_EN
            dlo_f_q <= '0;
`endif
            cmd_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            acc_q   <= acc_d;
            cmd_f_q <= cmd_f_d;
            dhi_f_q <= dhi_f_d;
`ifdef UART_CMD_CHECKSUM_EN
            dlo_f_q <= dlo_f_d;
`endif
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign cmd_valid_o = valid_q;
    assign cmd_o       = cmd_q;
    assign data_o      = data_q;
    assign err_o       = err_q;
    assign err_code_o  = code_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser against a byte-stream reference model.
module tb_uart_cmd_parser;

    localparam logic [7:0] Sync    = 8'hA5;
    localparam int         Timeout = 640;
`ifdef UART_CMD_CHECKSUM_EN
    localparam int         NData   = 4;
`else
    localparam int         NData   = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        done = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        tick = 1'b0;
    logic        ready = 1'b0;
    logic        cmd_valid;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        err;
    logic [1:0]  err_code;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: frame bytes collected after sync, ticks since last byte.
    bit         m_in_frame = 1'b0;
    logic [7:0] m_bytes[$];
    int         m_ticks = 0;
    bit         m_pend = 1'b0;
    logic [7:0] m_cmd = 8'h00;
    logic [15:0] m_data = 16'h0000;
    bit         m_err = 1'b0;
    logic [1:0] m_code = 2'b00;

    uart_cmd_parser dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .rx_done_tick_i(done),
        .rx_data_i     (din),
        .sample_tick_i (tick),
        .cmd_valid_o   (cmd_valid),
        .cmd_ready_i   (ready),
        .cmd_o         (cmd),
        .data_o        (data),
        .err_o         (err),
        .err_code_o    (err_code),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        m_err = 1'b0;
        if (!rst_n) begin
            m_in_frame = 1'b0;
            m_bytes.delete();
            m_ticks = 0;
            m_pend  = 1'b0;
            m_cmd   = 8'h00;
            m_data  = 16'h0000;
            m_code  = 2'b00;
            return;
        end
        if (m_pend) begin
            if (ready) begin
                m_pend = 1'b0;
                if (done && din == Sync) begin
                    m_in_frame = 1'b1;
                    m_bytes.delete();
                    m_ticks = 0;
                end
            end else if (done) begin
                m_err  = 1'b1;
                m_code = 2'b11;
            end
        end else if (!m_in_frame) begin
            if (done && din == Sync) begin
                m_in_frame = 1'b1;
                m_bytes.delete();
                m_ticks = 0;
            end
        end else if (done) begin
            m_bytes.push_back(din);
            m_ticks = 0;
            if (m_bytes.size() == NData) begin
                m_in_frame = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
                if ((m_bytes[0] ^ m_bytes[1] ^ m_bytes[2]) == m_bytes[3]) begin
                    m_pend = 1'b1;
                    m_cmd  = m_bytes[0];
                    m_data = {m_bytes[1], m_bytes[2]};
                end else begin
                    m_err  = 1'b1;
                    m_code = 2'b10;
                end
`else
                m_pend = 1'b1;
                m_cmd  = m_bytes[0];
                m_data = {m_bytes[1], m_bytes[2]};
`endif
            end
        end else if (tick) begin
            m_ticks++;
            if (m_ticks == Timeout) begin
                m_err      = 1'b1;
                m_code     = 2'b01;
                m_in_frame = 1'b0;
            end
        end
    endtask

    task automatic cyc(input logic d, input logic [7:0] b, input logic t, input logic r);
        @(negedge clk);
        done  = d;
        din   = b;
        tick  = t;
        ready = r;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic r);
        cyc(1'b1, b, 1'b0, r);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [15:0] dv, input logic r);
        logic [7:0] chk;
        chk = c ^ dv[15:8] ^ dv[7:0];
        send(Sync, r);
        send(c, r);
        send(dv[15:8], r);
        send(dv[7:0], r);
`ifdef UART_CMD_CHECKSUM_EN
        send(chk, r);
`else
        if (chk == 8'h00) cyc(1'b0, 8'h00, 1'b0, r);
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, Sync, 1'b1, 1'b1);
        n_tests++;
        if ({cmd_valid, cmd, data, err, err_code, busy} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset: valid=%b cmd=%h data=%h err=%b code=%b busy=%b, want all 0",
                     cmd_valid, cmd, data, err, err_code, busy);
        end
        rst_n = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        n_tests++;
        if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b valid=%b, want 0 0", busy, cmd_valid);
        end
    endtask

    task automatic test_basic();
        send_frame(8'h01, 16'h1234, 1'b1);
        n_tests++;
        if (cmd_valid !== 1'b1 || cmd !== 8'h01 || data !== 16'h1234 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic: valid=%b cmd=%h data=%h err=%b, want 1 01 1234 0",
                     cmd_valid, cmd, data, err);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        n_tests++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drop: valid=%b busy=%b, want 0 0", cmd_valid, busy);
        end
    endtask

    task automatic test_hold();
        int bad;
        bad = 0;
        send_frame(8'h01, 16'h1234, 1'b0);
        for (int i = 0; i < 50; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            if (cmd_valid !== 1'b1 || cmd !== 8'h01 || data !== 16'h1234 || busy !== 1'b1)
                bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold: %0d of 50 cycles lost valid/cmd/data, want 0", bad);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        n_tests++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: valid=%b busy=%b, want 0 0", cmd_valid, busy);
        end
    endtask

`ifdef UART_CMD_CHECKSUM_EN
    task automatic test_checksum();
        send(Sync, 1'b1);
        send(8'h01, 1'b1);
        send(8'h12, 1'b1);
        send(8'h34, 1'b1);
        send(8'h00, 1'b1);
        n_tests++;
        if (err !== 1'b1 || err_code !== 2'b10 || cmd_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL checksum: err=%b code=%b valid=%b busy=%b, want 1 10 0 0",
                     err, err_code, cmd_valid, busy);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        n_tests++;
        if (err !== 1'b0 || err_code !== 2'b10 || cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL checksum_after: err=%b code=%b valid=%b, want 0 10 0",
                     err, err_code, cmd_valid);
        end
    endtask
`endif

    task automatic test_timeout();
        int bad;
        bad = 0;
        send(Sync, 1'b0);
        send(8'h02, 1'b0);
        for (int i = 0; i < Timeout - 1; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            if (err !== 1'b0 || busy !== 1'b1) bad++;
        end
        // Byte on the terminal tick must win over the timeout.
        cyc(1'b1, 8'h12, 1'b1, 1'b0);
        if (err !== 1'b0 || busy !== 1'b1) bad++;
        for (int i = 0; i < Timeout - 1; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            if (err !== 1'b0 || busy !== 1'b1) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL timeout_early: %0d cycles with err or !busy, want 0", bad);
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        n_tests++;
        if (err !== 1'b1 || err_code !== 2'b01 || busy !== 1'b0 || cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout: err=%b code=%b busy=%b valid=%b, want 1 01 0 0",
                     err, err_code, busy, cmd_valid);
        end
        send_frame(8'h07, 16'hBEEF, 1'b0);
        n_tests++;
        if (cmd_valid !== 1'b1 || cmd !== 8'h07 || data !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL timeout_recover: valid=%b cmd=%h data=%h, want 1 07 beef",
                     cmd_valid, cmd, data);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_overrun();
        send_frame(8'h03, 16'hABCD, 1'b0);
        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        n_tests++;
        if (err !== 1'b1 || err_code !== 2'b11 || cmd_valid !== 1'b1 ||
            cmd !== 8'h03 || data !== 16'hABCD) begin
            n_fail++;
            $display("FAIL overrun: err=%b code=%b valid=%b cmd=%h data=%h, want 1 11 1 03 abcd",
                     err, err_code, cmd_valid, cmd, data);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        n_tests++;
        if (err !== 1'b0 || err_code !== 2'b11 || cmd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_pulse: err=%b code=%b valid=%b, want 0 11 1",
                     err, err_code, cmd_valid);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        send_frame(8'h11, 16'h2233, 1'b0);
        send(Sync, 1'b1);
        n_tests++;
        if (cmd_valid !== 1'b0 || busy !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_sync: valid=%b busy=%b err=%b, want 0 1 0", cmd_valid, busy, err);
        end
        send(8'h04, 1'b0);
        send(8'h56, 1'b0);
        send(8'h78, 1'b0);
`ifdef UART_CMD_CHECKSUM_EN
        send(8'h04 ^ 8'h56 ^ 8'h78, 1'b0);
`endif
        n_tests++;
        if (cmd_valid !== 1'b1 || cmd !== 8'h04 || data !== 16'h5678) begin
            n_fail++;
            $display("FAIL b2b_frame: valid=%b cmd=%h data=%h, want 1 04 5678",
                     cmd_valid, cmd, data);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        send(Sync, 1'b1);
        send(8'h01, 1'b1);
        send(8'h12, 1'b1);
        rst_n = 1'b0;
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        n_tests++;
        if ({cmd_valid, cmd, data, err, err_code, busy} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%b cmd=%h data=%h err=%b code=%b busy=%b, want all 0",
                     cmd_valid, cmd, data, err, err_code, busy);
        end
        rst_n = 1'b1;
        send(8'h34, 1'b1);
        send(8'h27, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        n_tests++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_tail: valid=%b busy=%b err=%b, want 0 0 0",
                     cmd_valid, busy, err);
        end
    endtask

    task automatic test_random();
        logic       d, t, r;
        logic [7:0] b;
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 599) != 0);
            d = ($urandom_range(0, 2) == 0);
            b = ($urandom_range(0, 3) == 0) ? Sync : 8'($urandom);
            t = ($urandom_range(0, 1) == 0);
            r = ($urandom_range(0, 3) != 0);
            cyc(d, b, t, r);
            n_tests++;
            if (cmd_valid !== m_pend || busy !== (m_in_frame || m_pend) || err !== m_err ||
                err_code !== m_code || cmd !== m_cmd || data !== m_data) begin
                n_fail++;
                $display("FAIL random[%0d]: valid=%b busy=%b err=%b code=%b cmd=%h data=%h, want %b %b %b %b %h %h",
                         i, cmd_valid, busy, err, err_code, cmd, data,
                         m_pend, (m_in_frame || m_pend), m_err, m_code, m_cmd, m_data);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
`ifdef UART_CMD_CHECKSUM_EN
        test_checksum();
`endif
        test_timeout();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
